// File: rtl/edma_pkg.sv
// Shared eDMA definitions: channel FSM state encodings, also used for
// status readback in the register file.
package edma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } edma_state_t;

endpackage

// File: rtl/edma_ctrl.sv
// eDMA channel controller: sequences one channel through IDLE/START/ACTIVE/
// DONE/ERROR, generates count/address update strobes and a sticky irq.
import edma_pkg::*;

module edma_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_en,
  input  logic        mastermode,
  input  logic        chainmode,
  input  logic        irqmask,
  input  logic [31:0] count_reg,
  input  logic        access_in,
  input  logic        wait_in,
  output logic        master_active,
  output logic        update,
  output logic        update2d,
  output logic        irq,
  output logic [2:0]  dma_state
);

  edma_state_t state_q, state_d;
  logic        entered_q, entered_d;
  logic        irq_q, irq_d;
  logic        last_xfer;

  always_comb begin
    master_active = (state_q == ST_ACTIVE) & mastermode;
    update        = (state_q == ST_ACTIVE) & dma_en & ~wait_in & (mastermode | access_in);
    update2d      = update & (count_reg[15:0] == 16'd1) & (count_reg[31:16] != 16'd0);
    last_xfer     = update & (count_reg == 32'd1);
    dma_state     = state_q;
    irq           = irq_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (dma_en) state_d = ST_START;
      ST_START:  state_d = (count_reg == '0) ? ST_ERROR : ST_ACTIVE;
      ST_ACTIVE: begin
        if (!dma_en)        state_d = ST_IDLE;
        else if (last_xfer) state_d = ST_DONE;
      end
      ST_DONE:   state_d = (chainmode & dma_en) ? ST_START : ST_IDLE;
      ST_ERROR:  if (!dma_en) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    entered_d = (state_d != state_q);
  end

  // irq is set during the first cycle spent in DONE/ERROR, so it becomes
  // visible one cycle after entry; a coincident clear loses to the set.
  always_comb begin
    irq_d = (entered_q & ((state_q == ST_DONE) | (state_q == ST_ERROR)) & ~irqmask)
          | (irq_q & dma_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      entered_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      entered_q <= entered_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_edma_ctrl.sv
// Directed bench for edma_ctrl with hand-computed per-cycle expectations.
module tb_edma_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dma_en = 1'b0;
  logic        mastermode = 1'b0;
  logic        chainmode = 1'b0;
  logic        irqmask = 1'b0;
  logic [31:0] count_reg = '0;
  logic        access_in = 1'b0;
  logic        wait_in = 1'b0;
  logic        master_active, update, update2d, irq;
  logic [2:0]  dma_state;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] cnt;

  edma_ctrl dut (
    .clk(clk), .reset(reset), .dma_en(dma_en), .mastermode(mastermode),
    .chainmode(chainmode), .irqmask(irqmask), .count_reg(count_reg),
    .access_in(access_in), .wait_in(wait_in), .master_active(master_active),
    .update(update), .update2d(update2d), .irq(irq), .dma_state(dma_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic up,
                         input logic up2d, input logic ma, input logic iq);
    check({tag, " state"}, {29'd0, dma_state}, {29'd0, st});
    check({tag, " update"}, {31'd0, update}, {31'd0, up});
    check({tag, " update2d"}, {31'd0, update2d}, {31'd0, up2d});
    check({tag, " master_active"}, {31'd0, master_active}, {31'd0, ma});
    check({tag, " irq"}, {31'd0, irq}, {31'd0, iq});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; dma_en = 1'b0; mastermode = 1'b0; chainmode = 1'b0;
    irqmask = 1'b0; count_reg = '0; access_in = 1'b0; wait_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [2:0] st1  [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd0, 3'd0};
  logic       up1  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       irq1 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [2:0] st3  [7] = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0};
  logic       irq3 [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       w4   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       a4   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [2:0] st6  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3};
  logic       up6  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    // 1D master transfer of 3, irq visible from cycle 6, cleared after dma_en falls
    do_reset();
    mastermode = 1'b1;
    cnt = 32'd3;
    for (int c = 0; c < 8; c++) begin
      dma_en = (c < 6);
      count_reg = cnt;
      #1;
      chk_out($sformatf("1d c%0d", c), st1[c], up1[c], 1'b0, up1[c], irq1[c]);
      if (up1[c]) cnt = cnt - 32'd1;
      tick();
    end

    // 2D wrap: inner count 1 with outer nonzero is not the last transfer
    do_reset();
    mastermode = 1'b1; dma_en = 1'b1; count_reg = 32'h0001_0001;
    tick(); tick();
    #1;
    chk_out("2d wrap", 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    count_reg = 32'h0001_0002;
    #1;
    chk_out("2d inner", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    count_reg = 32'h0000_0001;
    #1;
    chk_out("2d last", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    #1;
    chk_out("2d done", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Zero count -> ERROR; irqmask change after set has no effect
    do_reset();
    count_reg = '0;
    for (int c = 0; c < 7; c++) begin
      dma_en  = (c < 5);
      irqmask = (c == 4);
      #1;
      chk_out($sformatf("err c%0d", c), st3[c], 1'b0, 1'b0, 1'b0, irq3[c]);
      tick();
    end

    // Slave mode with back-pressure, then valid-gated updates
    do_reset();
    access_in = 1'b1; wait_in = 1'b1; dma_en = 1'b1; cnt = 32'd10; count_reg = cnt;
    tick(); tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk_out($sformatf("bp c%0d", c), 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      wait_in = w4[c]; access_in = a4[c]; count_reg = cnt;
      #1;
      chk_out($sformatf("slv c%0d", c), 3'd2, ~w4[c] & a4[c], 1'b0, 1'b0, 1'b0);
      if (~w4[c] & a4[c]) cnt = cnt - 32'd1;
      tick();
    end
    check("slv count", cnt, 32'd6);
    count_reg = 32'd1; wait_in = 1'b1;
    #1;
    chk_out("last+wait", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    wait_in = 1'b0;
    #1;
    chk_out("last held", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    chk_out("slv done", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    check("slv irq", {31'd0, irq}, 32'd1);

    // Abort mid-ACTIVE
    do_reset();
    mastermode = 1'b1; dma_en = 1'b1; count_reg = 32'd5;
    tick(); tick();
    #1;
    chk_out("abort act", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    dma_en = 1'b0; count_reg = 32'd4;
    #1;
    chk_out("abort drop", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    #1;
    chk_out("abort idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    chk_out("abort hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while in DONE
    do_reset();
    mastermode = 1'b1; dma_en = 1'b1; count_reg = 32'd1;
    tick(); tick(); tick();
    #1;
    chk_out("rst done", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0; dma_en = 1'b0;
    #1;
    chk_out("rst idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Chaining with irq masked
    do_reset();
    mastermode = 1'b1; chainmode = 1'b1; irqmask = 1'b1; count_reg = 32'd1;
    for (int c = 0; c < 7; c++) begin
      dma_en = 1'b1;
      #1;
      chk_out($sformatf("chain c%0d", c), st6[c], up6[c], 1'b0, st6[c] == 3'd2, 1'b0);
      tick();
    end
    dma_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edma_ctrl.md
EDMA_CTRL -- requirements
Module: edma_ctrl

Interface
REQ-001 The block SHALL have no parameters; state encodings SHALL come from the shared package.
REQ-002 clk  in  1  main clock; all state SHALL update on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 dma_en  in  1  channel enable from the config register; level-sensitive.
REQ-005 mastermode  in  1  1 = channel generates reads; 0 = channel forwards slave stream.
REQ-006 chainmode  in  1  1 = restart automatically after DONE while dma_en=1.
REQ-007 irqmask  in  1  1 = suppress irq.
REQ-008 count_reg  in  32  current count: [31:16] outer loop, [15:0] inner loop.
REQ-009 access_in  in  1  slave-mode data valid.
REQ-010 wait_in  in  1  pushback from the downstream datapath.
REQ-011 master_active  out  1  channel is issuing master transactions.
REQ-012 update  out  1  strobe: count/srcaddr/dstaddr registers take datapath next values.
REQ-013 update2d  out  1  strobe qualifier: this update wraps the inner loop.
REQ-014 irq  out  1  sticky completion/error interrupt.
REQ-015 dma_state  out  3  current FSM state encoding.

Function
REQ-016 The FSM SHALL have the states IDLE=0, START=1, ACTIVE=2, DONE=3, and ERROR=4, registered.
- IDLE: dma_en=1 -> START.
- START: lasts exactly 1 cycle; count_reg==0 -> ERROR, else -> ACTIVE.
- ACTIVE: last transfer -> DONE; dma_en=0 -> IDLE (abort).
- DONE: lasts 1 cycle; chainmode & dma_en -> START, else -> IDLE.
- ERROR: held until dma_en=0 -> IDLE.
REQ-017 The states 5 to 7 SHALL go to IDLE on the next cycle.
REQ-018 master_active SHALL be (state==ACTIVE) & mastermode, combinational from the registered state.
REQ-019 update SHALL be (state==ACTIVE) & dma_en & ~wait_in & (mastermode | access_in).
REQ-020 update2d SHALL be update & (count_reg[15:0]==1) & (count_reg[31:16]!=0).
REQ-021 The last transfer SHALL be defined as update & (count_reg[31:0]==1).
REQ-022 When the last transfer occurs, the FSM SHALL move to DONE in the following cycle.
REQ-023 When dma_en falls in ACTIVE, update SHALL be 0 that cycle and the FSM SHALL move to IDLE; no DONE and no irq SHALL follow.
REQ-024 If the last transfer and wait_in=1 occur together, no update SHALL occur and the FSM SHALL remain in ACTIVE.
REQ-025 Latency: dma_en rises in cycle 0 -> START in cycle 1 -> ACTIVE in cycle 2, with the first possible update in cycle 2.
REQ-026 irq SHALL be set on entry to DONE or ERROR when irqmask=0, and SHALL be cleared in the cycle after dma_en=0.
REQ-027 If set and clear coincide, set SHALL win.
REQ-028 An irq that is already set SHALL be unaffected by later changes to irqmask.
REQ-029 dma_state SHALL equal the registered state encoding.

Reset
REQ-030 On reset=1 at a clock edge, the state SHALL be IDLE and irq SHALL be 0.
REQ-031 While the state is IDLE after reset, master_active, update and update2d SHALL all be 0, and dma_state SHALL be 0.
REQ-032 Reset SHALL override every transition, including a reset applied mid-ACTIVE or in DONE.

Structure
REQ-033 The state encodings (IDLE..ERROR, 3 bits) SHALL reside in the shared edma package, which is also used by the register file for status readback.
REQ-034 The block SHALL be a single module with no sub-modules.
REQ-035 The next-state logic and the irq logic SHALL be separate processes.

Verification
REQ-036 The bench SHALL cover a 1D master transfer: dma_en=1, mastermode=1, count_reg=0x0000_0003 (decremented by the model on each update), wait_in=0 -> update in cycles 2, 3 and 4; DONE in cycle 5; irq=1 from cycle 6; master_active=1 only in cycles 2-4.
REQ-037 The bench SHALL cover a 2D wrap: count_reg=0x0001_0001 in ACTIVE with wait_in=0 -> update=1 and update2d=1, and no DONE.
REQ-038 The bench SHALL cover a count of zero: count_reg=0 at START -> ERROR; irq=1; dma_en=0 -> IDLE and irq=0 one cycle later.
REQ-039 The bench SHALL cover back-pressure and slave mode: mastermode=0, access_in=1, wait_in=1 for 4 cycles -> update=0 throughout; wait_in=0 -> a single update per valid cycle.
REQ-040 The bench SHALL cover abort and reset: dma_en=0 mid-ACTIVE -> IDLE with irq=0; in a separate run, reset=1 in DONE -> IDLE with irq=0 on the next edge.
REQ-041 The bench SHALL cover chaining: chainmode=1, dma_en=1, irqmask=1 at the last transfer -> DONE -> START -> ACTIVE, with irq held at 0.
